// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the I$/D$ miss arbiter in front of main memory:
//   DCACHE_LINE_WIDTH  width of one cache line moved to/from memory
//   memory_request_t   {addr, is_store, data} carried by a cache miss/evict
//   arb_state_e        arbiter FSM encoding (IDLE, ISSUE, WAIT_RSP, RESPOND)
//   CACHE_ID_I/_D      response target encoding on rsp_cache_id
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int MEM_ADDR_WIDTH    = 32;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0]    addr;
        logic                         is_store;
        logic [DCACHE_LINE_WIDTH-1:0] data;
    } memory_request_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_RSP = 2'd2,
        ARB_RESPOND  = 2'd3
    } arb_state_e;

    localparam logic CACHE_ID_I = 1'b0;
    localparam logic CACHE_ID_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every non-clock signal of the memory arbiter.
//   Cache side : icache/dcache request valid + info (in), response pulse,
//                line data and target id (out)
//   Memory side: request valid/info (out), ready (in), response valid/data
//                (in), sticky timeout flag (out)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (caches + memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                         icache_req_valid_miss;
    memory_request_t              icache_req_info_miss;
    logic                         dcache_req_valid_miss;
    memory_request_t              dcache_req_info_miss;
    logic                         rsp_valid_miss;
    logic [DCACHE_LINE_WIDTH-1:0] rsp_data_miss;
    logic                         rsp_cache_id;
    logic                         mem_req_valid;
    memory_request_t              mem_req_info;
    logic                         mem_req_ready;
    logic                         mem_rsp_valid;
    logic [DCACHE_LINE_WIDTH-1:0] mem_rsp_data;
    logic                         mem_timeout;

    modport slave (
        input  icache_req_valid_miss, icache_req_info_miss,
        input  dcache_req_valid_miss, dcache_req_info_miss,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output rsp_valid_miss, rsp_data_miss, rsp_cache_id,
        output mem_req_valid, mem_req_info, mem_timeout
    );

    modport master (
        output icache_req_valid_miss, icache_req_info_miss,
        output dcache_req_valid_miss, dcache_req_info_miss,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  rsp_valid_miss, rsp_data_miss, rsp_cache_id,
        input  mem_req_valid, mem_req_info, mem_timeout
    );

endinterface

// File: rtl/mem_arb_select.sv
// ---------------------------------------------------------------------------
// mem_arb_select
// Picks which cache is granted when the arbiter is free.
//   icache_req_i  I$ request pending
//   dcache_req_i  D$ request pending
//   last_grant_i  cache served by the previous grant (CACHE_ID_*)
//   grant_id_o    winning cache (CACHE_ID_*); only meaningful with a request
// Build option MEM_ARB_ROUND_ROBIN_EN: a tie goes to the cache not served
// last. Without it the D$ always wins a tie.
// ---------------------------------------------------------------------------
module mem_arb_select
    import mem_arbiter_pkg::*;
(
    input  logic icache_req_i,
    input  logic dcache_req_i,
    input  logic last_grant_i,
    output logic grant_id_o
);

    logic prefer_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign prefer_d = (last_grant_i == CACHE_ID_I);
`else
    // Fixed priority: the history input has no influence on the result.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign prefer_d          = 1'b1;
`endif

    always_comb begin
        grant_id_o = CACHE_ID_I;
        if (icache_req_i && dcache_req_i) begin
            grant_id_o = prefer_d ? CACHE_ID_D : CACHE_ID_I;
        end else if (dcache_req_i) begin
            grant_id_o = CACHE_ID_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Serialises I$ and D$ miss/evict requests onto a single main-memory port,
// one transaction at a time: grant -> issue -> wait for response -> one-cycle
// response pulse back to the requesting cache.
// Parameters:
//   TIMEOUT_CYCLES  max WAIT_RSP cycles before mem_timeout is raised
// Ports:
//   clock   single clock, rising edge
//   reset   asynchronous, active-high
//   arb_if  mem_arbiter_if.slave (cache requests/responses, memory port)
// Build option MEM_ARB_ROUND_ROBIN_EN (see mem_arb_select): alternating tie
// break instead of fixed D$ priority.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  arb_if
);

    localparam logic [1:0] ST_IDLE     = ARB_IDLE;
    localparam logic [1:0] ST_ISSUE    = ARB_ISSUE;
    localparam logic [1:0] ST_WAIT_RSP = ARB_WAIT_RSP;
    localparam logic [1:0] ST_RESPOND  = ARB_RESPOND;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    // The counter holds (WAIT_RSP cycles so far - 1), so the last allowed
    // cycle is recognised when it equals TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]                   state_q, state_d;
    memory_request_t              req_info_q, req_info_d;
    logic                         grant_id_q, grant_id_d;
    logic                         last_grant_q, last_grant_d;
    logic [DCACHE_LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         timeout_q, timeout_d;

    logic winner_id;
    logic any_req;

    assign any_req = arb_if.icache_req_valid_miss | arb_if.dcache_req_valid_miss;

    mem_arb_select u_select (
        .icache_req_i (arb_if.icache_req_valid_miss),
        .dcache_req_i (arb_if.dcache_req_valid_miss),
        .last_grant_i (last_grant_q),
        .grant_id_o   (winner_id)
    );

    always_comb begin
        state_d      = state_q;
        req_info_d   = req_info_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;

        case (state_q)
            ST_IDLE: begin
                // Grants happen only here, so RESPOND is always followed by
                // at least one IDLE cycle in which the served cache drops
                // its valid before it could be re-granted.
                if (any_req) begin
                    grant_id_d   = winner_id;
                    last_grant_d = winner_id;
                    req_info_d   = (winner_id == CACHE_ID_D) ? arb_if.dcache_req_info_miss
                                                             : arb_if.icache_req_info_miss;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (arb_if.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // A response arriving in the last allowed cycle still wins.
                if (arb_if.mem_rsp_valid) begin
                    rsp_data_d = arb_if.mem_rsp_data;
                    cnt_d      = '0;
                    state_d    = ST_RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_info_q   <= '0;
            grant_id_q   <= CACHE_ID_I;
            last_grant_q <= CACHE_ID_I;
            rsp_data_q   <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_info_q   <= req_info_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign arb_if.mem_req_valid  = (state_q == ST_ISSUE);
    assign arb_if.mem_req_info   = req_info_q;
    assign arb_if.rsp_valid_miss = (state_q == ST_RESPOND);
    assign arb_if.rsp_data_miss  = rsp_data_q;
    assign arb_if.rsp_cache_id   = grant_id_q;
    assign arb_if.mem_timeout    = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 8). A cycle-level
// cache/memory environment presents requests, accepts them after a chosen
// ready delay and answers after a chosen response delay. Grant order comes
// from the arbitration rule (fixed D$ priority, or alternating with
// MEM_ARB_ROUND_ROBIN_EN); response data is whatever the memory side sent.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock  (clock),
        .reset  (reset),
        .arb_if (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic model_last = 1'b0;   // cache served last (1 = D$)
    logic cur_id     = 1'b0;

    typedef struct {
        logic         iv, dv;
        logic [31:0]  iaddr, daddr;
        logic         istore, dstore;
        int           rdly, sdly;
        logic [127:0] data;
        int           exp_rsps;
        logic         exp_first;
    } vec_t;

    vec_t vecs[8];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic memory_request_t mk(input logic [31:0] a, input logic st, input logic [127:0] d);
        memory_request_t r;
        r.addr     = a;
        r.is_store = st;
        r.data     = d;
        return r;
    endfunction

    function automatic vec_t mkv(input logic iv, input logic dv, input logic [31:0] ia, input logic [31:0] da,
                                 input logic ist, input logic dst, input int rdly, input int sdly,
                                 input logic [127:0] data, input logic exp_first);
        vec_t v;
        v.iv = iv; v.dv = dv; v.iaddr = ia; v.daddr = da; v.istore = ist; v.dstore = dst;
        v.rdly = rdly; v.sdly = sdly; v.data = data;
        v.exp_rsps  = int'(iv) + int'(dv);
        v.exp_first = exp_first;
        return v;
    endfunction

    // Arbitration rule: a lone requester wins; a tie goes to D$, or with the
    // round-robin build to whichever cache was not served last.
    function automatic logic pick(input logic iv, input logic dv, input logic last);
        if (iv && dv) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return !last;
`else
            return 1'b1;
`endif
        end
        return dv;
    endfunction

    task automatic check_all_zero(input string tag);
        check_bit({tag, " rsp_valid"},  bus.rsp_valid_miss, 1'b0);
        check_vec({tag, " rsp_data"},   192'(bus.rsp_data_miss), 192'(0));
        check_bit({tag, " rsp_id"},     bus.rsp_cache_id, 1'b0);
        check_bit({tag, " req_valid"},  bus.mem_req_valid, 1'b0);
        check_vec({tag, " req_info"},   192'(bus.mem_req_info), 192'(0));
        check_bit({tag, " timeout"},    bus.mem_timeout, 1'b0);
    endtask

    // Presents the requests and plays both caches and memory until every
    // presented request has been answered (or the cycle budget runs out).
    task automatic run_scenario(input string tag, input memory_request_t ir, input memory_request_t dr,
                                input logic iv, input logic dv, input int rdly, input int sdly,
                                input logic [127:0] dbase, input int exp_rsps,
                                input logic use_exp, input logic exp_first);
        int ph = 0;
        int issue_cnt = 0;
        int wcnt = 0;
        int grants = 0;
        int rsp_seen = 0;
        int budget = 0;
        logic just_resp = 1'b0;
        logic win = 1'b0;
        memory_request_t exp_info = '0;
        logic [127:0] cur_data = '0;

        bus.icache_req_info_miss  = ir;
        bus.dcache_req_info_miss  = dr;
        bus.icache_req_valid_miss = iv;
        bus.dcache_req_valid_miss = dv;
        while ((bus.icache_req_valid_miss || bus.dcache_req_valid_miss) && budget < 200) begin
            tick();
            budget++;
            bus.mem_req_ready = 1'b0;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = ~cur_data;
            if (ph == 0) begin
                check_bit({tag, " no rsp while idle"}, bus.rsp_valid_miss, 1'b0);
                if (just_resp) begin
                    check_bit({tag, " idle after rsp"}, bus.mem_req_valid, 1'b0);
                    just_resp = 1'b0;
                end else if (bus.mem_req_valid) begin
                    win = (use_exp && grants == 0) ? exp_first
                        : pick(bus.icache_req_valid_miss, bus.dcache_req_valid_miss, model_last);
                    exp_info   = win ? dr : ir;
                    cur_id     = win;
                    model_last = win;
                    cur_data   = dbase + 128'(grants);
                    grants++;
                    issue_cnt  = 0;
                    ph         = 1;
                end
            end
            if (ph == 1) begin
                check_bit({tag, " req valid"}, bus.mem_req_valid, 1'b1);
                check_vec({tag, " req info"}, 192'(bus.mem_req_info), 192'(exp_info));
                check_bit({tag, " no rsp in issue"}, bus.rsp_valid_miss, 1'b0);
                issue_cnt++;
                if (issue_cnt > rdly) begin
                    bus.mem_req_ready = 1'b1;
                    ph   = 2;
                    wcnt = 0;
                end
            end else if (ph == 2) begin
                wcnt++;
                check_bit({tag, " no req in wait"}, bus.mem_req_valid, 1'b0);
                check_bit({tag, " no rsp in wait"}, bus.rsp_valid_miss, 1'b0);
                if (wcnt > sdly) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = cur_data;
                    ph = 3;
                end
            end else if (ph == 3) begin
                check_bit({tag, " rsp pulse"}, bus.rsp_valid_miss, 1'b1);
                check_bit({tag, " rsp id"}, bus.rsp_cache_id, cur_id);
                check_vec({tag, " rsp data"}, 192'(bus.rsp_data_miss), 192'(cur_data));
                check_bit({tag, " no req in respond"}, bus.mem_req_valid, 1'b0);
                if (cur_id) bus.dcache_req_valid_miss = 1'b0;
                else        bus.icache_req_valid_miss = 1'b0;
                rsp_seen++;
                just_resp = 1'b1;
                ph = 0;
            end
        end
        bus.icache_req_valid_miss = 1'b0;
        bus.dcache_req_valid_miss = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        check_vec({tag, " rsp count"}, 192'(rsp_seen), 192'(exp_rsps));
        tick();
        check_bit({tag, " pulse ended"}, bus.rsp_valid_miss, 1'b0);
        check_bit({tag, " idle after txn"}, bus.mem_req_valid, 1'b0);
        $display("txn %s: grants=%0d responses=%0d", tag, grants, rsp_seen);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ab;
        ab = {16{8'hAB}};

        vecs[0] = mkv(1, 0, 32'h100, 32'h0,   0, 0, 0, 1, ab, 1'b0);                  // lone I$ load
        vecs[1] = mkv(1, 1, 32'h140, 32'h240, 0, 0, 0, 1, {4{32'h11223344}}, 1'b1);   // tie -> D$ first
        vecs[2] = mkv(0, 1, 32'h0,   32'h380, 0, 1, 0, 0, {4{32'h55667788}}, 1'b1);   // D$ store
        vecs[3] = mkv(1, 0, 32'h400, 32'h0,   0, 0, 5, 3, {4{32'h0BADF00D}}, 1'b0);   // ready low 5 cycles
        for (int k = 4; k < 8; k++)                                                    // repeated ties
            vecs[k] = mkv(1, 1, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 0, 0, 0, 2,
                          {4{32'hC0DE0000 + 32'(k)}}, 1'b1);

        bus.icache_req_valid_miss = 1'b0;
        bus.icache_req_info_miss  = '0;
        bus.dcache_req_valid_miss = 1'b0;
        bus.dcache_req_info_miss  = '0;
        bus.mem_req_ready         = 1'b0;
        bus.mem_rsp_valid         = 1'b0;
        bus.mem_rsp_data          = '0;

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        model_last = 1'b0;
        tick();
        check_all_zero("after reset");

        // Directed vectors
        for (int k = 0; k < 8; k++) begin
            run_scenario($sformatf("vec%0d", k),
                         mk(vecs[k].iaddr, vecs[k].istore, vecs[k].istore ? ~vecs[k].data : '0),
                         mk(vecs[k].daddr, vecs[k].dstore, vecs[k].dstore ? ~vecs[k].data : '0),
                         vecs[k].iv, vecs[k].dv, vecs[k].rdly, vecs[k].sdly,
                         vecs[k].data, vecs[k].exp_rsps, 1'b1, vecs[k].exp_first);
        end

        // Randomised traffic
        for (int k = 0; k < 40; k++) begin
            logic iv, dv;
            iv = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            if (!iv && !dv) iv = 1'b1;
            run_scenario($sformatf("rnd%0d", k),
                         mk($urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}),
                         mk($urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}),
                         iv, dv, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                         {$urandom, $urandom, $urandom, $urandom},
                         int'(iv) + int'(dv), 1'b0, 1'b0);
        end

        // Timeout: memory never answers
        bus.icache_req_info_miss  = mk(32'h200, 1'b0, '0);
        bus.icache_req_valid_miss = 1'b1;
        for (int k = 0; k < 10 && !bus.mem_req_valid; k++) tick();
        check_bit("to issue", bus.mem_req_valid, 1'b1);
        model_last = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.icache_req_valid_miss = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            check_bit($sformatf("to wait%0d flag", k), bus.mem_timeout, 1'b0);
            check_bit($sformatf("to wait%0d rsp", k), bus.rsp_valid_miss, 1'b0);
            tick();
        end
        check_bit("to flag set", bus.mem_timeout, 1'b1);
        check_bit("to no rsp", bus.rsp_valid_miss, 1'b0);
        check_bit("to back idle", bus.mem_req_valid, 1'b0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = {4{32'hDEADBEEF}};
        tick();
        bus.mem_rsp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_bit($sformatf("to late%0d rsp", k), bus.rsp_valid_miss, 1'b0);
            check_bit($sformatf("to late%0d sticky", k), bus.mem_timeout, 1'b1);
            check_bit($sformatf("to late%0d idle", k), bus.mem_req_valid, 1'b0);
            tick();
        end
        $display("txn timeout: flag=%b", bus.mem_timeout);

        // Reset during WAIT_RSP, then a late memory response
        bus.dcache_req_info_miss  = mk(32'h300, 1'b1, {4{32'h12345678}});
        bus.dcache_req_valid_miss = 1'b1;
        for (int k = 0; k < 10 && !bus.mem_req_valid; k++) tick();
        check_bit("rst issue", bus.mem_req_valid, 1'b1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        check_all_zero("rst async");
        bus.dcache_req_valid_miss = 1'b0;
        tick();
        reset = 1'b0;
        model_last = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = {4{32'hFEEDFACE}};
        tick();
        bus.mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_all_zero($sformatf("rst late%0d", k));
            tick();
        end
        $display("txn reset_mid_wait: rsp_valid=%b", bus.rsp_valid_miss);

        // Recovery after reset: first tie again goes to D$
        run_scenario("post_reset", mk(32'h500, 1'b0, '0), mk(32'h600, 1'b0, '0),
                     1'b1, 1'b1, 1, 1, {4{32'h600DCAFE}}, 2, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: the maximum number of WAIT_RSP cycles before a timeout is flagged.
- REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-004 SHALL have port icache_req_valid_miss, input, 1, I$ miss request; held high until the I$ response.
- REQ-005 SHALL have port icache_req_info_miss, input, memory_request_t, I$ request; stable while valid.
- REQ-006 SHALL have port dcache_req_valid_miss, input, 1, D$ miss or evict request; held high until the D$ response.
- REQ-007 SHALL have port dcache_req_info_miss, input, memory_request_t, D$ request; stable while valid.
- REQ-008 SHALL have port rsp_valid_miss, output, 1, one-cycle response pulse to the caches.
- REQ-009 SHALL have port rsp_data_miss, output, DCACHE_LINE_WIDTH, returned line.
- REQ-010 SHALL have port rsp_cache_id, output, 1, response target: 0 = I$, 1 = D$.
- REQ-011 SHALL have port mem_req_valid, output, 1, request to main memory.
- REQ-012 SHALL have port mem_req_info, output, memory_request_t, granted request, registered.
- REQ-013 SHALL have port mem_req_ready, input, 1, memory accepts the request when both valid and ready are high.
- REQ-014 SHALL have port mem_rsp_valid, input, 1, memory response pulse.
- REQ-015 SHALL have port mem_rsp_data, input, DCACHE_LINE_WIDTH, memory response line.
- REQ-016 SHALL have port mem_timeout, output, 1, sticky flag set when a memory response timed out.

Function
- REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT_RSP and RESPOND.
- REQ-018 In IDLE with at least one request valid, SHALL select a winner per REQ-028/029, register its info and id, and move to ISSUE.
- REQ-019 In ISSUE, SHALL drive mem_req_valid=1 with mem_req_info constant and move to WAIT_RSP on the cycle mem_req_ready=1.
- REQ-020 In WAIT_RSP, SHALL count cycles; on mem_rsp_valid it SHALL register mem_rsp_data and move to RESPOND.
- REQ-021 In RESPOND, SHALL drive rsp_valid_miss=1 for exactly one cycle with the registered data and id, then return to IDLE.
- REQ-022 Store requests (is_store=1) SHALL complete the same way; rsp_data_miss then carries the memory-returned value, and the cache treats the pulse as an acknowledgement.
- REQ-023 Response latency SHALL be at least 3 cycles from grant; a new grant SHALL never occur in a RESPOND cycle, so there is at least 1 IDLE cycle between responses and the cache can drop its valid.
- REQ-024 Only one transaction SHALL be outstanding at a time; a non-granted request waits with no loss.
- REQ-025 rsp_valid_miss SHALL be 0 outside RESPOND, and mem_req_valid SHALL be 0 outside ISSUE.
- REQ-026 If the WAIT_RSP count reaches TIMEOUT_CYCLES, SHALL set mem_timeout, return to IDLE without a response, and clear the counter.
- REQ-027 A mem_rsp_valid outside WAIT_RSP SHALL be ignored.

Configuration
- REQ-028 With MEM_ARB_ROUND_ROBIN_EN defined, the winner on simultaneous requests SHALL be the cache not served last; the last-grant register resets to I$, so D$ wins the first tie.
- REQ-029 Without MEM_ARB_ROUND_ROBIN_EN, D$ SHALL always win simultaneous requests (fixed priority).

Reset
- REQ-030 While reset is high, SHALL force state IDLE, rsp_valid_miss=0, rsp_data_miss=0, rsp_cache_id=0, mem_req_valid=0, mem_req_info=0, mem_timeout=0, counter=0, and last-grant=I$.
- REQ-031 Reset asserted mid-transaction SHALL drop the transaction; an in-flight memory response arriving after reset SHALL be ignored per REQ-027.

Structure
- REQ-032 memory_request_t (addr, is_store, data), the FSM state enum, and DCACHE_LINE_WIDTH SHALL live in the shared soc package/header.
- REQ-033 Arbitration SHALL be a sub-module mem_arb_select (requests, last-grant -> winner id), with no other sub-modules.

Verification
- REQ-034 A lone I$ load to addr 0x100, with memory ready and responding 2 cycles later with 0xAB..: SHALL give rsp_valid_miss=1 and rsp_cache_id=0 with that data, at exactly one pulse.
- REQ-035 I$ and D$ valid in the same cycle without the macro: SHALL serve D$ first and I$ next, with at least 1 IDLE cycle between the two pulses.
- REQ-036 Same stimulus as REQ-035 repeated 4 times with MEM_ARB_ROUND_ROBIN_EN: grants SHALL follow D,I,D,I,D,I,D,I.
- REQ-037 mem_req_ready held low for 5 cycles: mem_req_valid and mem_req_info SHALL stay stable, with a handshake on the 6th cycle.
- REQ-038 No mem_rsp_valid with TIMEOUT_CYCLES=8: mem_timeout SHALL be set after 8 WAIT_RSP cycles, with no rsp_valid_miss and a return to IDLE.
- REQ-039 Reset pulsed during WAIT_RSP, then a late mem_rsp_valid: all outputs SHALL be zero and no response SHALL be generated.
